// File: rtl/slug_port_pkg.sv
// Shared constants and types for the slug port link: port bit positions,
// down-path FSM states and the default FIFO depth.
// Latency: n/a (package). Backpressure: n/a.
package slug_port_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int BYTE_W    = 8;

  // Bits of the CPU output port (CPU -> link)
  localparam int PO_UP_TOG = 8;
  localparam int PO_DN_ACK = 12;

  // Bits of the CPU input port (link -> CPU)
  localparam int PI_DN_TOG     = 8;
  localparam int PI_UP_ACK     = 12;
  localparam int PI_ST_DN_NE   = 16;
  localparam int PI_ST_UP_FULL = 17;

  typedef enum logic {
    DN_IDLE     = 1'b0,
    DN_WAIT_ACK = 1'b1
  } dn_state_e;

endpackage

// File: rtl/slug_fifo.sv
// Generic synchronous FIFO, power-of-two depth, head shown combinationally.
// Latency: pushed data visible at the head on the edge after the push.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk/rst (async active-low), push/push_data, pop/pop_data,
//        full, empty, count (occupancy, $clog2(DEPTH)+1 bits).
module slug_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/slug_port_link.sv
// Byte link between a host stream interface and a CPU toggle-handshake port.
// Latency: host byte into empty down FIFO on edge N shows on port_in at N+2;
//          CPU up toggle is acked and queued one edge after it is seen.
// Backpressure: h_tx_ready = down FIFO not full; a CPU up toggle is held
//          unacked while the up FIFO is full and taken on the first edge with space.
// Ports: clk, rst (async active-low), port_out (from CPU), port_in (to CPU),
//        h_tx_data/h_tx_valid/h_tx_ready (host -> CPU),
//        h_rx_data/h_rx_valid/h_rx_ready (CPU -> host).
// Optional: define SLUG_PORT_LINK_STATUS_EN to drive port_in[17:16] status bits.
module slug_port_link
  import slug_port_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] port_out,
  output logic [31:0] port_in,
  input  logic [7:0]  h_tx_data,
  input  logic        h_tx_valid,
  output logic        h_tx_ready,
  output logic [7:0]  h_rx_data,
  output logic        h_rx_valid,
  input  logic        h_rx_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  dn_state_e         r_dn_state;
  logic [BYTE_W-1:0] r_dn_byte;
  logic              r_dn_tog;
  logic              r_dn_avail;
  logic              r_last_up;
  logic              r_up_ack;

  logic              w_dn_full;
  logic              w_dn_empty;
  logic              w_dn_pop;
  logic [BYTE_W-1:0] w_dn_head;
  logic              w_up_full;
  logic              w_up_empty;
  logic              w_up_push;
  logic [CW-1:0]     w_unused_dn_cnt;
  logic [CW-1:0]     w_unused_up_cnt;
  logic              w_unused_po;

  assign w_unused_po = &{1'b0, port_out[31:13], port_out[11:9]};

  // ---------------- down path: host -> CPU ----------------
  assign h_tx_ready = ~w_dn_full;

  // r_dn_avail is the registered non-empty flag; gating the pop on it adds
  // the extra edge that gives the two-edge push-to-port latency.
  assign w_dn_pop = (r_dn_state == DN_IDLE) & r_dn_avail & ~w_dn_empty;

  slug_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_dn_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (h_tx_valid),
    .push_data (h_tx_data),
    .pop       (w_dn_pop),
    .pop_data  (w_dn_head),
    .full      (w_dn_full),
    .empty     (w_dn_empty),
    .count     (w_unused_dn_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dn_state <= DN_IDLE;
      r_dn_byte  <= '0;
      r_dn_tog   <= 1'b0;
      r_dn_avail <= 1'b0;
    end else begin
      r_dn_avail <= ~w_dn_empty;
      case (r_dn_state)
        DN_IDLE: begin
          if (w_dn_pop) begin
            r_dn_byte  <= w_dn_head;
            r_dn_tog   <= ~r_dn_tog;
            r_dn_state <= DN_WAIT_ACK;
          end
        end
        DN_WAIT_ACK: begin
          if (port_out[PO_DN_ACK] == r_dn_tog) r_dn_state <= DN_IDLE;
        end
        default: r_dn_state <= DN_IDLE;
      endcase
    end
  end

  // ---------------- up path: CPU -> host ----------------
  // Full is sampled before any same-edge host pop, so a pop on a full FIFO
  // never lets the pending toggle in on that same edge.
  assign w_up_push  = (port_out[PO_UP_TOG] ^ r_last_up) & ~w_up_full;
  assign h_rx_valid = ~w_up_empty;

  slug_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_up_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_up_push),
    .push_data (port_out[7:0]),
    .pop       (h_rx_ready),
    .pop_data  (h_rx_data),
    .full      (w_up_full),
    .empty     (w_up_empty),
    .count     (w_unused_up_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_up <= 1'b0;
      r_up_ack  <= 1'b0;
    end else if (w_up_push) begin
      r_last_up <= port_out[PO_UP_TOG];
      r_up_ack  <= ~r_up_ack;
    end
  end

  // ---------------- CPU input port assembly ----------------
`ifdef SLUG_PORT_LINK_STATUS_EN
  logic r_st_up_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_st_up_full <= 1'b0;
    else      r_st_up_full <= w_up_full;
  end
`endif

  always_comb begin
    port_in            = '0;
    port_in[7:0]       = r_dn_byte;
    port_in[PI_DN_TOG] = r_dn_tog;
    port_in[PI_UP_ACK] = r_up_ack;
`ifdef SLUG_PORT_LINK_STATUS_EN
    port_in[PI_ST_DN_NE]   = r_dn_avail;
    port_in[PI_ST_UP_FULL] = r_st_up_full;
`else
    port_in[PI_ST_UP_FULL:PI_ST_DN_NE] = 2'b00;
`endif
  end

endmodule

// File: tb/tb_slug_port_link.sv
// Scoreboard bench for slug_port_link: directed latency/backpressure/reset
// scenarios plus a randomized two-direction stream checked by monitors.
module tb_slug_port_link;

  localparam int DEPTH = 4;
`ifdef SLUG_PORT_LINK_STATUS_EN
  localparam bit ST_EN = 1'b1;
`else
  localparam bit ST_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] port_out;
  logic [31:0] port_in;
  logic [7:0]  h_tx_data;
  logic        h_tx_valid;
  logic        h_tx_ready;
  logic [7:0]  h_rx_data;
  logic        h_rx_valid;
  logic        h_rx_ready;

  // CPU-side model state
  logic [7:0] cpu_up_byte;
  logic       cpu_up_tog;
  logic       ack_man, ack_auto, ack_en;
  logic       rx_man, rx_rand, rx_en;

  assign port_out   = {19'd0, (ack_en ? ack_auto : ack_man), 3'd0, cpu_up_tog, cpu_up_byte};
  assign h_rx_ready = rx_en ? rx_rand : rx_man;

  int         n_vec;
  int         n_err;
  logic [7:0] dn_q[$];
  logic [7:0] up_q[$];

  slug_port_link #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .port_out   (port_out),
    .port_in    (port_in),
    .h_tx_data  (h_tx_data),
    .h_tx_valid (h_tx_valid),
    .h_tx_ready (h_tx_ready),
    .h_rx_data  (h_rx_data),
    .h_rx_valid (h_rx_valid),
    .h_rx_ready (h_rx_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_send(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    h_tx_data  = d;
    h_tx_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (h_tx_ready) begin
        dn_q.push_back(d);
        ok = 1'b1;
      end
      tick();
    end
    h_tx_valid = 1'b0;
    check("host_send_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic host_try(input logic [7:0] d, output bit ok);
    ok = 1'b0;
    h_tx_data  = d;
    h_tx_valid = 1'b1;
    @(negedge clk);
    if (h_tx_ready) begin
      dn_q.push_back(d);
      ok = 1'b1;
    end
    tick();
    h_tx_valid = 1'b0;
  endtask

  task automatic cpu_flip(input logic [7:0] d);
    cpu_up_byte = d;
    tick();
    cpu_up_tog = ~cpu_up_tog;
    up_q.push_back(d);
  endtask

  task automatic wait_up_ack(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      tick();
      if (port_in[12] == cpu_up_tog) ok = 1'b1;
    end
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && (dn_q.size() != 0 || up_q.size() != 0); i++) tick();
    check("drain_down_q", dn_q.size(), 0);
    check("drain_up_q", up_q.size(), 0);
  endtask

  // CPU acker for the down path: copies the toggle back after a random delay.
  initial begin
    forever begin
      @(negedge clk);
      if (ack_en && rst && (port_in[8] != ack_auto)) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        tick();
        ack_auto = port_in[8];
      end
    end
  end

  // Random host readiness on the up path.
  initial begin
    rx_rand = 1'b0;
    forever begin
      tick();
      rx_rand = ($urandom_range(0, 2) != 0);
    end
  end

  // Down-path monitor: each toggle change on port_in[8] is one presented byte.
  initial begin : dn_mon
    logic dn_prev;
    logic dn_prev_acked;
    dn_prev       = 1'b0;
    dn_prev_acked = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        dn_prev       = 1'b0;
        dn_prev_acked = 1'b1;
      end else begin
        if (port_in[8] != dn_prev) begin
          check("dn_presented_after_ack", {31'd0, dn_prev_acked}, 32'd1);
          if (dn_q.size() == 0) begin
            check("dn_unexpected_byte", {24'd0, port_in[7:0]}, 32'hFFFF_FFFF);
          end else begin
            check("dn_byte", {24'd0, port_in[7:0]}, {24'd0, dn_q.pop_front()});
          end
          dn_prev = port_in[8];
        end
        dn_prev_acked = (port_out[12] == dn_prev);
      end
    end
  end

  // Up-path monitor: compare the head whenever the host accepts it.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && h_rx_valid && h_rx_ready) begin
        if (up_q.size() == 0) begin
          check("up_unexpected_byte", {24'd0, h_rx_data}, 32'hFFFF_FFFF);
        end else begin
          check("up_byte", {24'd0, h_rx_data}, {24'd0, up_q.pop_front()});
        end
      end
    end
  end

  initial begin : main
    bit ok;
    int acc;
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    h_tx_data = 8'd0;  h_tx_valid = 1'b0;
    cpu_up_byte = 8'd0; cpu_up_tog = 1'b0;
    ack_man = 1'b0; ack_auto = 1'b0; ack_en = 1'b0;
    rx_man = 1'b0; rx_en = 1'b0;

    // Reset state
    #2;
    check("rst_port_in", port_in, 32'd0);
    check("rst_rx_valid", {31'd0, h_rx_valid}, 32'd0);
    check("rst_tx_ready", {31'd0, h_tx_ready}, 32'd1);
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();

    // CPU sends 0x3C: visible to host and acked one edge after the flip
    cpu_flip(8'h3C);
    tick();
    check("up_first_valid", {31'd0, h_rx_valid}, 32'd1);
    check("up_first_data", {24'd0, h_rx_data}, 32'h3C);
    check("up_first_ack", {31'd0, port_in[12]}, 32'd1);
    rx_man = 1'b1;
    wait_drain(50);
    rx_man = 1'b0;

    // Up FIFO full: fifth toggle held until the host frees a slot
    for (int k = 0; k < DEPTH; k++) begin
      cpu_flip(k[7:0]);
      wait_up_ack(8, ok);
      check("up_fill_ack", {31'd0, ok}, 32'd1);
    end
    cpu_flip(8'(DEPTH));
    repeat (4) tick();
    check("up_full_noack", {31'd0, port_in[12]}, {31'd0, ~cpu_up_tog});
    check("up_full_status", {31'd0, port_in[17]}, {31'd0, ST_EN});
    rx_man = 1'b1;
    tick();
    check("up_pop_only_edge", {31'd0, port_in[12]}, {31'd0, ~cpu_up_tog});
    tick();
    check("up_push_next_edge", {31'd0, port_in[12]}, {31'd0, cpu_up_tog});
    wait_drain(50);
    rx_man = 1'b0;

    // Host 0xA5: presented exactly two edges after the push edge
    check("tx_ready_idle", {31'd0, h_tx_ready}, 32'd1);
    h_tx_data = 8'hA5;
    h_tx_valid = 1'b1;
    dn_q.push_back(8'hA5);
    tick();
    h_tx_valid = 1'b0;
    check("dn_lat_edge1", {31'd0, port_in[8]}, 32'd0);
    tick();
    check("dn_lat_edge2", {31'd0, port_in[8]}, 32'd0);
    tick();
    check("dn_lat_tog", {31'd0, port_in[8]}, 32'd1);
    check("dn_lat_byte", {24'd0, port_in[7:0]}, 32'hA5);
    host_send(8'h5A);
    repeat (2) tick();
    check("dn_hold_unacked", {24'd0, port_in[7:0]}, 32'hA5);
    ack_man = 1'b1;
    tick();
    check("dn_ack_edge_tog", {31'd0, port_in[8]}, 32'd1);
    tick();
    check("dn_next_tog", {31'd0, port_in[8]}, 32'd0);
    check("dn_next_byte", {24'd0, port_in[7:0]}, 32'h5A);
    ack_man = 1'b0;
    repeat (3) tick();

    // Back-to-back host bytes with an acking CPU
    ack_auto = ack_man;
    ack_en = 1'b1;
    host_send(8'h11);
    host_send(8'h22);
    host_send(8'h33);
    wait_drain(200);

    // Randomized traffic in both directions
    rx_en = 1'b1;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 2)) tick();
          host_send(8'($urandom_range(0, 255)));
        end
      end
      begin
        bit ok2;
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) tick();
          cpu_flip(8'($urandom_range(0, 255)));
          wait_up_ack(64, ok2);
          check("rand_up_ack", {31'd0, ok2}, 32'd1);
        end
      end
    join
    wait_drain(2000);
    rx_en = 1'b0;
    repeat (4) tick();

    // Down FIFO fill without acks, then reset mid-stream
    ack_man = ack_auto;
    ack_en = 1'b0;
    rx_man = 1'b0;
    cpu_flip(8'h99);
    wait_up_ack(8, ok);
    check("pre_rst_up_ack", {31'd0, ok}, 32'd1);
    repeat (3) tick();
    acc = 0;
    ok = 1'b1;
    for (int i = 0; i < DEPTH + 4 && ok; i++) begin
      host_try(8'h40 + 8'(i), ok);
      if (ok) acc++;
    end
    check("dn_fill_count", acc, DEPTH + 1);
    check("dn_full_tx_ready", {31'd0, h_tx_ready}, 32'd0);
    check("dn_nonempty_status", {31'd0, port_in[16]}, {31'd0, ST_EN});
    check("up_pending_valid", {31'd0, h_rx_valid}, 32'd1);
    tick();
    rst = 1'b0;
    cpu_up_tog = 1'b0;
    cpu_up_byte = 8'd0;
    ack_man = 1'b0;
    #1;
    check("midrst_port_in", port_in, 32'd0);
    check("midrst_rx_valid", {31'd0, h_rx_valid}, 32'd0);
    check("midrst_tx_ready", {31'd0, h_tx_ready}, 32'd1);
    dn_q.delete();
    up_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    repeat (4) tick();
    check("postrst_port_in", port_in, 32'd0);
    check("postrst_rx_valid", {31'd0, h_rx_valid}, 32'd0);
    check("postrst_tx_ready", {31'd0, h_tx_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
